// File: rtl/demux_pkg.sv
// Shared defaults, slot state type and drop-counter helpers for demux_stream.
package demux_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 8;
  localparam int DEF_SELW  = 3;

  // The drop counter is a fixed 8-bit saturating counter.
  localparam int                 DROP_W   = 8;
  localparam logic [DROP_W-1:0]  DROP_MAX = 8'd255;

  // A channel slot is either holding a word or waiting for one.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Increment that sticks at DROP_MAX instead of wrapping.
  function automatic logic [DROP_W-1:0] satInc(input logic [DROP_W-1:0] value);
    if (value == DROP_MAX) begin
      return value;
    end
    return value + DROP_W'(1);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single channel. A write always wins over a
// drain, so a slot that is drained and written in the same cycle stays full
// and takes the new word.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  slot_state_e      r_state;
  slot_state_e      w_nextState;
  logic [WIDTH-1:0] r_data;

  // Next-state decode: fill on write, empty on a drain that has no write.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      SLOT_EMPTY: begin
        if (wr) begin
          w_nextState = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (wr) begin
          w_nextState = SLOT_FULL;
        end else if (ready) begin
          w_nextState = SLOT_EMPTY;
        end
      end
      default: w_nextState = SLOT_EMPTY;
    endcase
  end

  // State register; reset throws away any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Data register only moves on a write, so a stalled word stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (wr) begin
      r_data <= wdata;
    end
  end

  assign valid = (r_state == SLOT_FULL);
  assign data  = r_data;

endmodule

// File: rtl/demux_stream.sv
// Stream demultiplexer: routes each input word to one channel slot (unicast)
// or to every slot at once (broadcast). Unicast to a channel number that does
// not exist is accepted and discarded, and counted in a saturating counter.
module demux_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int SELW  = DEF_SELW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_bcast,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [DROP_W-1:0]    drop_cnt
);

  logic [NCH-1:0]    w_selHit;
  logic [NCH-1:0]    w_canAccept;
  logic [NCH-1:0]    w_wr;
  logic              w_selLegal;
  logic              w_inReady;
  logic              w_fire;
  logic              w_drop;
  logic [DROP_W-1:0] r_dropCnt;

  // One-hot decode of the select; all zeros when the select names no channel.
  always_comb begin
    w_selHit = '0;
    for (int k = 0; k < NCH; k++) begin
      if (in_sel == SELW'(k)) begin
        w_selHit[k] = 1'b1;
      end
    end
  end

  // A slot can take a word if it is empty or is being drained this cycle.
  assign w_canAccept = ~out_valid | out_ready;
  assign w_selLegal  = |w_selHit;

  // Ready is built only from select, broadcast flag and slot handshake state,
  // never from in_valid, so upstream may wait on ready before asserting valid.
  always_comb begin
    w_inReady = 1'b1;
    if (in_bcast) begin
      w_inReady = &w_canAccept;
    end else if (w_selLegal) begin
      w_inReady = |(w_selHit & w_canAccept);
    end
  end

  assign in_ready = w_inReady;
  assign w_fire   = in_valid & w_inReady;
  assign w_drop   = w_fire & ~in_bcast & ~w_selLegal;

  // Per-slot write strobes: every slot on broadcast, the selected one otherwise.
  always_comb begin
    w_wr = '0;
    if (w_fire) begin
      w_wr = in_bcast ? {NCH{1'b1}} : w_selHit;
    end
  end

  // Saturating count of words discarded for an out-of-range select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dropCnt <= '0;
    end else if (w_drop) begin
      r_dropCnt <= satInc(r_dropCnt);
    end
  end

  assign drop_cnt = r_dropCnt;

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .wr   (w_wr[k]),
      .wdata(in_data),
      .ready(out_ready[k]),
      .valid(out_valid[k]),
      .data (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: an 8-channel instance checked every cycle
// against a slot-array model, plus a 6-channel instance for drop counting.
module tb_demux_stream;

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic        in_bcast;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [63:0] out_data;
  logic [7:0]  drop_cnt;

  logic        in6_valid;
  logic        in6_ready;
  logic [7:0]  in6_data;
  logic [2:0]  in6_sel;
  logic        in6_bcast;
  logic [5:0]  out6_valid;
  logic [5:0]  out6_ready;
  logic [47:0] out6_data;
  logic [7:0]  drop6_cnt;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  // Model of the 8-channel instance: one entry per channel plus drop count.
  bit         mValid [8];
  logic [7:0] mData  [8];
  int         mDrop;

  demux_stream #(.WIDTH(8), .NCH(8), .SELW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  demux_stream #(.WIDTH(8), .NCH(6), .SELW(3)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in6_valid), .in_ready(in6_ready), .in_data(in6_data),
    .in_sel(in6_sel), .in_bcast(in6_bcast),
    .out_valid(out6_valid), .out_ready(out6_ready), .out_data(out6_data),
    .drop_cnt(drop6_cnt)
  );

  // Free-running clock.
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Ready rule taken straight from the channel handshake definition.
  function automatic bit modelReady();
    int sel;
    bit ok;
    sel = int'(in_sel);
    if (in_bcast) begin
      ok = 1;
      for (int k = 0; k < 8; k++) ok = ok && (!mValid[k] || out_ready[k]);
      return ok;
    end
    if (sel < 8) return !mValid[sel] || out_ready[sel];
    return 1;
  endfunction

  // Model update on each clock edge; reset clears everything asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        mValid[k] = 0;
        mData[k]  = 8'h00;
      end
      mDrop = 0;
    end else begin
      bit fire;
      bit wrote [8];
      fire = in_valid && modelReady();
      for (int k = 0; k < 8; k++) wrote[k] = fire && (in_bcast || int'(in_sel) == k);
      if (fire && !in_bcast && int'(in_sel) >= 8) mDrop = (mDrop < 255) ? mDrop + 1 : 255;
      for (int k = 0; k < 8; k++) begin
        if (wrote[k]) begin
          mValid[k] = 1;
          mData[k]  = in_data;
        end else if (mValid[k] && out_ready[k]) begin
          mValid[k] = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      logic [7:0] expV;
      for (int k = 0; k < 8; k++) expV[k] = mValid[k];
      checkOutput("model in_ready", {63'd0, in_ready}, {63'd0, modelReady()});
      checkOutput("model out_valid", {56'd0, out_valid}, {56'd0, expV});
      checkOutput("model drop_cnt", {56'd0, drop_cnt}, 64'(mDrop));
      for (int k = 0; k < 8; k++) begin
        if (mValid[k]) checkOutput("model ch data", {56'd0, out_data[k*8 +: 8]}, {56'd0, mData[k]});
      end
    end
  end

  task automatic applyStimulus(input bit v, input logic [7:0] d, input logic [2:0] s,
                               input bit b, input logic [7:0] r);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    in_bcast  = b;
    out_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0;
    in_valid = 0; in_data = 0; in_sel = 0; in_bcast = 0; out_ready = 8'hFF;
    in6_valid = 0; in6_data = 0; in6_sel = 0; in6_bcast = 0; out6_ready = 6'h3F;
    #2 checkEn = 1;
    tick();

    // Reset state and ready during reset.
    checkOutput("reset out_valid", {56'd0, out_valid}, 64'h0);
    checkOutput("reset drop_cnt", {56'd0, drop_cnt}, 64'h0);
    applyStimulus(1, 8'hEE, 3'd0, 1, 8'h00);
    checkOutput("reset bcast in_ready", {63'd0, in_ready}, 64'h1);
    tick();
    checkOutput("no write in reset", {56'd0, out_valid}, 64'h0);
    applyStimulus(0, 8'h00, 3'd0, 0, 8'hFF);
    rst_n = 1;

    // Single unicast, latency one, then drained.
    applyStimulus(1, 8'hA5, 3'd3, 0, 8'hFF);
    tick();
    checkOutput("uni valid", {56'd0, out_valid}, 64'h08);
    checkOutput("uni data", {56'd0, out_data[31:24]}, 64'hA5);
    applyStimulus(0, 8'h00, 3'd3, 0, 8'hFF);
    tick();
    checkOutput("uni drained", {56'd0, out_valid}, 64'h00);

    // Backpressure on channel 2.
    applyStimulus(1, 8'h11, 3'd2, 0, 8'hFB);
    checkOutput("bp first ready", {63'd0, in_ready}, 64'h1);
    tick();
    applyStimulus(1, 8'h22, 3'd2, 0, 8'hFB);
    checkOutput("bp stalled ready", {63'd0, in_ready}, 64'h0);
    tick();
    checkOutput("bp held data", {56'd0, out_data[23:16]}, 64'h11);
    applyStimulus(1, 8'h22, 3'd2, 0, 8'hFF);
    checkOutput("bp release ready", {63'd0, in_ready}, 64'h1);
    tick();
    checkOutput("bp second data", {56'd0, out_data[23:16]}, 64'h22);
    checkOutput("bp second valid", {56'd0, out_valid}, 64'h04);
    applyStimulus(0, 8'h00, 3'd0, 0, 8'hFF);
    tick();

    // Broadcast blocked by a full, stalled slot 6, then released.
    applyStimulus(1, 8'h77, 3'd6, 0, 8'hBF);
    tick();
    applyStimulus(1, 8'h5A, 3'd0, 1, 8'hBF);
    checkOutput("bcast blocked ready", {63'd0, in_ready}, 64'h0);
    tick();
    checkOutput("bcast blocked valid", {56'd0, out_valid}, 64'h40);
    checkOutput("bcast blocked ch6", {56'd0, out_data[55:48]}, 64'h77);
    applyStimulus(1, 8'h5A, 3'd0, 1, 8'hFF);
    checkOutput("bcast free ready", {63'd0, in_ready}, 64'h1);
    tick();
    checkOutput("bcast valid", {56'd0, out_valid}, 64'hFF);
    checkOutput("bcast data", out_data, 64'h5A5A5A5A5A5A5A5A);
    applyStimulus(0, 8'h00, 3'd0, 0, 8'hFF);
    tick();

    // Back-to-back alternating unicast at full rate.
    applyStimulus(1, 8'h01, 3'd0, 0, 8'hFF); tick();
    checkOutput("b2b w1", {48'd0, out_valid, out_data[7:0]}, 64'h0101);
    applyStimulus(1, 8'h02, 3'd1, 0, 8'hFF); tick();
    checkOutput("b2b w2", {48'd0, out_valid, out_data[15:8]}, 64'h0202);
    applyStimulus(1, 8'h03, 3'd0, 0, 8'hFF); tick();
    checkOutput("b2b w3", {48'd0, out_valid, out_data[7:0]}, 64'h0103);
    applyStimulus(1, 8'h04, 3'd1, 0, 8'hFF); tick();
    checkOutput("b2b w4", {48'd0, out_valid, out_data[15:8]}, 64'h0204);
    applyStimulus(0, 8'h00, 3'd0, 0, 8'hFF); tick();

    // Mixed directed vectors, checked by the model every cycle.
    applyStimulus(1, 8'h30, 3'd4, 0, 8'h00); tick();
    applyStimulus(1, 8'h31, 3'd4, 0, 8'h00); tick();
    applyStimulus(1, 8'h32, 3'd5, 0, 8'h10); tick();
    applyStimulus(1, 8'h33, 3'd0, 1, 8'h30); tick();
    applyStimulus(1, 8'h34, 3'd7, 0, 8'hCF); tick();
    applyStimulus(0, 8'h35, 3'd7, 0, 8'hFF); tick();
    applyStimulus(1, 8'h36, 3'd7, 1, 8'hFF); tick();
    applyStimulus(1, 8'h37, 3'd1, 0, 8'h00); tick();

    // Illegal selects on the 6-channel instance: dropped and counted.
    in6_valid = 1; in6_sel = 3'd7; in6_data = 8'hD0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("drop in_ready", {63'd0, in6_ready}, 64'h1);
      tick();
    end
    checkOutput("drop no valid", {58'd0, out6_valid}, 64'h0);
    checkOutput("drop count 3", {56'd0, drop6_cnt}, 64'd3);
    for (int i = 0; i < 252; i++) tick();
    checkOutput("drop count 255", {56'd0, drop6_cnt}, 64'd255);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("drop saturated", {56'd0, drop6_cnt}, 64'd255);
    in6_sel = 3'd5; in6_data = 8'h3C;
    tick();
    checkOutput("nch6 legal valid", {58'd0, out6_valid}, 64'h20);
    checkOutput("nch6 legal data", {56'd0, out6_data[47:40]}, 64'h3C);
    in6_valid = 0;

    // Fill every slot, then reset mid-cycle.
    applyStimulus(1, 8'h99, 3'd0, 1, 8'h00); tick();
    checkOutput("fill valid", {56'd0, out_valid}, 64'hFF);
    applyStimulus(0, 8'h00, 3'd0, 0, 8'h00);
    #1 rst_n = 0;
    #1;
    checkOutput("async reset valid", {56'd0, out_valid}, 64'h0);
    checkOutput("async reset data", out_data, 64'h0);
    checkOutput("async reset drop", {56'd0, drop6_cnt}, 64'h0);
    tick();
    rst_n = 1;
    applyStimulus(1, 8'h42, 3'd6, 0, 8'hFF); tick();
    checkOutput("post reset write", {56'd0, out_valid}, 64'h40);
    applyStimulus(0, 8'h00, 3'd0, 0, 8'hFF); tick();
    tick();

    checkEn = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
